// File: rtl/toggle_gen_multi.sv
// rtl/toggle_gen_multi.sv - per-channel pulse-to-toggle CDC encoder with ack handshake and replay counter
// Optional sticky overflow flags are built when TOGGLE_GEN_MULTI_OVF_EN is defined.
module toggle_gen_multi #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       pulse,
  output logic [NUM_CH-1:0]       toggle,
  input  logic [NUM_CH-1:0]       ack_toggle,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH*CNT_W-1:0] pending,
  output logic [NUM_CH-1:0]       overflow,
  input  logic [NUM_CH-1:0]       ovf_clr
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0] ack_s;
  logic [NUM_CH-1:0] done;
  logic [NUM_CH-1:0] toggle_q, toggle_d;
  logic [NUM_CH-1:0] drop;
  state_t            state_q [NUM_CH];
  state_t            state_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q   [NUM_CH];
  logic [CNT_W-1:0]  cnt_d   [NUM_CH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= ack_toggle;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign ack_s = sync_q[SYNC_STAGES-1];
  // The in-flight toggle is acknowledged once the echoed level matches ours.
  assign done  = ~(ack_s ^ toggle_q);

  always_comb begin
    toggle_d = toggle_q;
    drop     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        IDLE: begin
          if (pulse[i]) begin
            toggle_d[i] = ~toggle_q[i];
            state_d[i]  = WAIT;
          end
        end
        WAIT: begin
          if (done[i]) begin
            if (cnt_q[i] != '0) begin
              toggle_d[i] = ~toggle_q[i];
              if (!pulse[i]) cnt_d[i] = cnt_q[i] - CNT_ONE;
            end else if (pulse[i]) begin
              toggle_d[i] = ~toggle_q[i];
            end else begin
              state_d[i] = IDLE;
            end
          end else if (pulse[i]) begin
            if (cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + CNT_ONE;
            else                     drop[i]  = 1'b1;
          end
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      toggle_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      toggle_q <= toggle_d;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  always_comb begin
    busy    = '0;
    pending = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      busy[i]                    = (state_q[i] == WAIT);
      pending[i*CNT_W +: CNT_W]  = cnt_q[i];
    end
  end

  assign toggle = toggle_q;

`ifdef TOGGLE_GEN_MULTI_OVF_EN
  logic [NUM_CH-1:0] ovf_q, ovf_d;

  // A drop in the same cycle as a clear must remain visible.
  assign ovf_d = drop | (ovf_q & ~ovf_clr);

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= '0;
    else     ovf_q <= ovf_d;
  end

  assign overflow = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ^{ovf_clr, drop};
  assign overflow   = '0;
`endif

endmodule

// File: tb/tb_toggle_gen_multi.sv
// tb/tb_toggle_gen_multi.sv - directed self-checking bench for toggle_gen_multi
// Destination domain is modelled as an echo of toggle that can be frozen per channel.
module tb_toggle_gen_multi;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 3;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [NUM_CH-1:0]       pulse = '0;
  logic [NUM_CH-1:0]       toggle;
  logic [NUM_CH-1:0]       ack_toggle = '0;
  logic [NUM_CH-1:0]       busy;
  logic [NUM_CH*CNT_W-1:0] pending;
  logic [NUM_CH-1:0]       overflow;
  logic [NUM_CH-1:0]       ovf_clr = '0;

  logic [NUM_CH-1:0] ack_en = '1;
  logic [NUM_CH-1:0] h0 = '0, h1 = '0;

  int checks = 0;
  int failures = 0;

  toggle_gen_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .pulse(pulse), .toggle(toggle), .ack_toggle(ack_toggle),
    .busy(busy), .pending(pending), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  // Echo: ack_toggle follows toggle two samples later, frozen while ack_en is low.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        h0 = '0;
        h1 = '0;
        ack_toggle = '0;
      end else begin
        h1 = h0;
        h0 = toggle;
        for (int i = 0; i < NUM_CH; i++) if (ack_en[i]) ack_toggle[i] = h1[i];
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
    checks++; if (toggle !== 4'h0) begin failures++; $display("FAIL reset_toggle got=%0h exp=0", toggle); end
    checks++; if (busy !== 4'h0) begin failures++; $display("FAIL reset_busy got=%0h exp=0", busy); end
    checks++; if (pending !== 12'h0) begin failures++; $display("FAIL reset_pending got=%0h exp=0", pending); end
    checks++; if (overflow !== 4'h0) begin failures++; $display("FAIL reset_overflow got=%0h exp=0", overflow); end
  endtask

  task automatic test_single;
    pulse[0] = 1'b1;
    tick(1);
    pulse[0] = 1'b0;
    checks++; if (toggle[0] !== 1'b1) begin failures++; $display("FAIL single_toggle got=%0b exp=1", toggle[0]); end
    checks++; if (busy[0] !== 1'b1) begin failures++; $display("FAIL single_busy_set got=%0b exp=1", busy[0]); end
    tick(3);
    checks++; if (busy[0] !== 1'b1) begin failures++; $display("FAIL single_busy_hold got=%0b exp=1", busy[0]); end
    tick(1);
    checks++; if (busy[0] !== 1'b0) begin failures++; $display("FAIL single_busy_fall got=%0b exp=0", busy[0]); end
    checks++; if (toggle !== 4'h1) begin failures++; $display("FAIL single_others got=%0h exp=1", toggle); end
  endtask

  task automatic test_burst;
    pulse[1] = 1'b1;
    tick(1);
    checks++; if (toggle[1] !== 1'b1) begin failures++; $display("FAIL burst_t0 got=%0b exp=1", toggle[1]); end
    tick(1);
    checks++; if (pending[5:3] !== 3'd1) begin failures++; $display("FAIL burst_pend1 got=%0d exp=1", pending[5:3]); end
    tick(1);
    pulse[1] = 1'b0;
    checks++; if (pending[5:3] !== 3'd2) begin failures++; $display("FAIL burst_pend2 got=%0d exp=2", pending[5:3]); end
    tick(2);
    checks++; if (toggle[1] !== 1'b0 || pending[5:3] !== 3'd1) begin
      failures++; $display("FAIL burst_t1 got=%0b/%0d exp=0/1", toggle[1], pending[5:3]);
    end
    tick(4);
    checks++; if (toggle[1] !== 1'b1 || pending[5:3] !== 3'd0 || busy[1] !== 1'b1) begin
      failures++; $display("FAIL burst_t2 got=%0b/%0d/%0b exp=1/0/1", toggle[1], pending[5:3], busy[1]);
    end
    tick(3);
    checks++; if (busy[1] !== 1'b1) begin failures++; $display("FAIL burst_busy_hold got=%0b exp=1", busy[1]); end
    tick(1);
    checks++; if (busy[1] !== 1'b0) begin failures++; $display("FAIL burst_busy_fall got=%0b exp=0", busy[1]); end
  endtask

  task automatic test_saturate;
    int  tog_cnt;
    logic prev;
    bit  ended;
    ack_en[2] = 1'b0;
    pulse[2]  = 1'b1;
    tick(10);
    pulse[2]  = 1'b0;
    checks++; if (pending[8:6] !== 3'd7) begin failures++; $display("FAIL sat_pending got=%0d exp=7", pending[8:6]); end
`ifdef TOGGLE_GEN_MULTI_OVF_EN
    checks++; if (overflow[2] !== 1'b1) begin failures++; $display("FAIL sat_overflow got=%0b exp=1", overflow[2]); end
`else
    checks++; if (overflow[2] !== 1'b0) begin failures++; $display("FAIL sat_overflow got=%0b exp=0", overflow[2]); end
`endif
    tog_cnt   = 1;
    prev      = toggle[2];
    ended     = 1'b0;
    ack_en[2] = 1'b1;
    for (int c = 0; c < 200 && !ended; c++) begin
      tick(1);
      if (toggle[2] !== prev) tog_cnt++;
      prev = toggle[2];
      if (busy[2] === 1'b0) ended = 1'b1;
    end
    checks++; if (!ended) begin failures++; $display("FAIL sat_drain_timeout got=busy exp=idle"); end
    checks++; if (tog_cnt != 8) begin failures++; $display("FAIL sat_toggles got=%0d exp=8", tog_cnt); end
    checks++; if (pending[8:6] !== 3'd0) begin failures++; $display("FAIL sat_drained got=%0d exp=0", pending[8:6]); end
`ifdef TOGGLE_GEN_MULTI_OVF_EN
    checks++; if (overflow[2] !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%0b exp=1", overflow[2]); end
    ovf_clr[2] = 1'b1;
    tick(1);
    ovf_clr[2] = 1'b0;
    checks++; if (overflow[2] !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%0b exp=0", overflow[2]); end
`endif
  endtask

  task automatic test_back_to_back;
    pulse[3] = 1'b1;
    tick(1);
    pulse[3] = 1'b0;
    checks++; if (toggle[3] !== 1'b1) begin failures++; $display("FAIL b2b_first got=%0b exp=1", toggle[3]); end
    tick(3);
    pulse[3] = 1'b1;
    tick(1);
    pulse[3] = 1'b0;
    checks++; if (toggle[3] !== 1'b0 || pending[11:9] !== 3'd0 || busy[3] !== 1'b1) begin
      failures++; $display("FAIL b2b_second got=%0b/%0d/%0b exp=0/0/1", toggle[3], pending[11:9], busy[3]);
    end
    tick(4);
    checks++; if (busy[3] !== 1'b0 || toggle[3] !== 1'b0) begin
      failures++; $display("FAIL b2b_idle got=%0b/%0b exp=0/0", busy[3], toggle[3]);
    end
  endtask

  task automatic test_reset_mid;
    ack_en[0] = 1'b0;
    pulse[0]  = 1'b1;
    tick(4);
    pulse[0]  = 1'b0;
    checks++; if (busy[0] !== 1'b1 || pending[2:0] !== 3'd3) begin
      failures++; $display("FAIL mid_setup got=%0b/%0d exp=1/3", busy[0], pending[2:0]);
    end
    rst = 1'b1;
    tick(1);
    checks++; if (toggle !== 4'h0 || busy !== 4'h0 || pending !== 12'h0 || overflow !== 4'h0) begin
      failures++; $display("FAIL mid_reset got=%0h/%0h/%0h/%0h exp=0/0/0/0", toggle, busy, pending, overflow);
    end
    rst = 1'b0;
    ack_en[0] = 1'b1;
    tick(1);
    pulse[0] = 1'b1;
    tick(1);
    pulse[0] = 1'b0;
    checks++; if (toggle[0] !== 1'b1 || busy[0] !== 1'b1) begin
      failures++; $display("FAIL mid_restart got=%0b/%0b exp=1/1", toggle[0], busy[0]);
    end
    tick(4);
    checks++; if (busy[0] !== 1'b0) begin failures++; $display("FAIL mid_restart_idle got=%0b exp=0", busy[0]); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_saturate();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
